addsub_share_ctrl: RTL and testbench

- Sequencing controller and two-port round-robin arbiter that shares one 4-bit ripple adder-subtractor datapath, the team's `adder_sub` block (inputs a, b, mode m; outputs s, carry), between two requesters.
- Accepts one operation at a time through valid/ready handshakes, registers operands, drives the datapath, registers the result, and returns it on a single response channel tagged with the requester id.
- Sits between the two client blocks and the arithmetic unit.

---
 rtl/addsub_share_pkg.sv | 28 ++
 rtl/adder_sub.sv | 26 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/addsub_share_ctrl.sv | 147 ++++++++++++++
 tb/tb_addsub_share_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/addsub_share_pkg.sv
// Shared types and constants for the two-requester add/sub sharing controller.
package addsub_share_pkg;

  // Width of the shared arithmetic datapath; the controller operand width must match it.
  localparam int ADDSUB_W = 4;

  // Width of the requester id carried with each operation.
  localparam int ID_W = 1;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Two's-complement overflow of a +/- b given the datapath sum.
  // The effective second operand is b inverted when subtracting.
  function automatic logic calc_ovf(input logic [ADDSUB_W-1:0] a,
                                    input logic [ADDSUB_W-1:0] b,
                                    input logic                sub,
                                    input logic [ADDSUB_W-1:0] s);
    logic [ADDSUB_W-1:0] b_eff;
    b_eff    = b ^ {ADDSUB_W{sub}};
    calc_ovf = (a[ADDSUB_W-1] == b_eff[ADDSUB_W-1]) && (s[ADDSUB_W-1] != a[ADDSUB_W-1]);
  endfunction

endpackage

// File: rtl/adder_sub.sv
// 4-bit ripple adder-subtractor: m=0 gives a+b, m=1 gives a-b (carry=1 means no borrow).
module adder_sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  output logic [3:0] s,
  output logic       carry
);

  logic       c;
  logic       bx;

  // Ripple chain; mode bit inverts b and feeds the initial carry for subtraction.
  always_comb begin
    s  = '0;
    c  = m;
    bx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bx   = b[i] ^ m;
      s[i] = a[i] ^ bx ^ c;
      c    = (a[i] & bx) | (a[i] & c) | (bx & c);
    end
    carry = c;
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone valid wins, a tie goes to the prio input.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // One-hot grant; nothing is granted while disabled.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        gnt_o = prio_i ? 2'b10 : 2'b01;
      end else begin
        gnt_o = valid_i;
      end
    end
  end

endmodule

// File: rtl/addsub_share_ctrl.sv
// Sequencing controller sharing one adder_sub between two requesters.
// Handshakes: a transfer happens in a cycle where valid and ready are both high;
// requesters hold valid and operands stable until ready, the consumer sees
// rsp_* stable while rsp_valid is high and rsp_ready is low.
// Flow: IDLE (accept, capture operands) -> CALC (run datapath, register result)
// -> RESP (present result until taken) -> IDLE.
module addsub_share_ctrl
  import addsub_share_pkg::*;
#(
  parameter int INIT_PRIO = 0,
  parameter int W         = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_carry,
  output logic         rsp_ovf,
  output logic         busy
);

  // The datapath is a fixed 4-bit unit; any other operand width cannot work.
  if (W != ADDSUB_W) begin : g_bad_width
    $error("addsub_share_ctrl: W must equal %0d", ADDSUB_W);
  end

  localparam logic PRIO_RST = (INIT_PRIO != 0);

  state_e              state_q;
  logic                prio_q;
  logic                prio_d;
  logic [W-1:0]        op_a_q,  op_a_d;
  logic [W-1:0]        op_b_q,  op_b_d;
  logic                op_sub_q, op_sub_d;
  logic [ID_W-1:0]     op_id_q, op_id_d;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [W-1:0]        rsp_sum_q;
  logic                rsp_carry_q;
  logic                rsp_ovf_q;

  logic [1:0]          gnt;
  logic                arb_en;
  logic [W-1:0]        dp_s;
  logic                dp_carry;
  logic                dp_ovf;

  // Requests are only considered in IDLE and never while reset is held.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arb2 u_arb (
    .valid_i ({req1_valid, req0_valid}),
    .prio_i  (prio_q),
    .en_i    (arb_en),
    .gnt_o   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Operand capture mux and the priority update: the loser of this grant wins next tie.
  always_comb begin
    op_a_d   = gnt[1] ? req1_a   : req0_a;
    op_b_d   = gnt[1] ? req1_b   : req0_b;
    op_sub_d = gnt[1] ? req1_sub : req0_sub;
    op_id_d  = gnt[1];
    prio_d   = gnt[0];
  end

  adder_sub u_dp (
    .a     (op_a_q),
    .b     (op_b_q),
    .m     (op_sub_q),
    .s     (dp_s),
    .carry (dp_carry)
  );

  assign dp_ovf = calc_ovf(op_a_q, op_b_q, op_sub_q, dp_s);

  // Controller FSM with all operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= PRIO_RST;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sub_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_sub_q <= op_sub_d;
            op_id_q  <= op_id_d;
            prio_q   <= prio_d;
            state_q  <= CALC;
          end
        end
        CALC: begin
          rsp_sum_q   <= dp_s;
          rsp_carry_q <= dp_carry;
          rsp_ovf_q   <= dp_ovf;
          rsp_id_q    <= op_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Directed bench for addsub_share_ctrl: reset, add/sub vectors, contention,
// backpressure and reset during an operation.
module tb_addsub_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_sub;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sub;
  logic [3:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf, busy;
  logic [3:0] rsp_sum;

  int n_vec = 0;
  int n_err = 0;

  // Expected responses: {id, sum[3:0], carry, ovf}.
  logic [6:0] exp_q[$];

  // Packed views: {valid,id,sum,carry,ovf} and {0,busy,ready1,ready0}.
  logic [7:0] rsp_vec;
  logic [7:0] ctl_vec;
  assign rsp_vec = {rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf};
  assign ctl_vec = {5'b0, busy, req1_ready, req0_ready};

  addsub_share_ctrl #(.INIT_PRIO(0), .W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [3:0] a, input logic [3:0] b, input logic s);
    req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
  endtask

  task automatic drive1(input logic v, input logic [3:0] a, input logic [3:0] b, input logic s);
    req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
  endtask

  // One uncontended operation, starting at posedge+1 of an IDLE cycle, rsp_ready high.
  // After acceptance the requester inputs are scrambled to show they are not reused.
  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [3:0] e_sum, input logic e_c, input logic e_o);
    exp_q.push_back({id, e_sum, e_c, e_o});
    if (id) drive1(1'b1, a, b, s);
    else    drive0(1'b1, a, b, s);
    samp();
    chk("hs_ready", ctl_vec, id ? 8'h02 : 8'h01);
    tick();
    drive0(1'b0, ~a, ~b, ~s);
    drive1(1'b0, ~a, ~b, ~s);
    samp();
    chk("calc_ctl", ctl_vec, 8'h04);
    chk("calc_valid", {7'b0, rsp_valid}, 8'h00);
    tick();
    samp();
    chk("resp_ctl", ctl_vec, 8'h04);
    chk("resp", rsp_vec, {1'b1, exp_q.pop_front()});
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive0(1'b1, 4'd1, 4'd1, 1'b0);
    drive1(1'b1, 4'd2, 4'd2, 1'b0);
    #2;
    // Reset state: no ready even with valids asserted, all outputs zero.
    chk("rst_ctl", ctl_vec, 8'h00);
    chk("rst_rsp", rsp_vec, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    drive0(1'b0, 4'd0, 4'd0, 1'b0);
    drive1(1'b0, 4'd0, 4'd0, 1'b0);

    // Directed arithmetic vectors.
    do_op(1'b0, 4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1);
    do_op(1'b1, 4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0);
    do_op(1'b1, 4'd9,  4'd2, 1'b1, 4'd7,  1'b1, 1'b1);
    do_op(1'b0, 4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0);
    do_op(1'b1, 4'd0,  4'd0, 1'b1, 4'd0,  1'b1, 1'b0);

    // Reset during CALC: grant to 0 moves prio to 1, reset must restore it to 0.
    drive0(1'b1, 4'd4, 4'd4, 1'b0);
    samp();
    chk("abort_hs", ctl_vec, 8'h01);
    tick();
    drive0(1'b0, 4'd0, 4'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", ctl_vec, 8'h00);
    chk("abort_rsp", rsp_vec, 8'h00);
    tick();
    samp();
    chk("abort_hold", rsp_vec, 8'h00);
    tick();
    rst_n = 1'b1;

    // Continuous contention: grants alternate 0,1,0,1, three cycles per op.
    drive0(1'b1, 4'd7, 4'd1, 1'b0);
    drive1(1'b1, 4'd2, 4'd6, 1'b1);
    for (int k = 0; k < 4; k++) begin
      samp();
      chk("cont_hs", ctl_vec, k[0] ? 8'h02 : 8'h01);
      chk("cont_idle_rsp", {7'b0, rsp_valid}, 8'h00);
      tick();
      samp();
      chk("cont_calc", ctl_vec, 8'h04);
      tick();
      samp();
      chk("cont_resp_ctl", ctl_vec, 8'h04);
      chk("cont_resp", rsp_vec, k[0] ? {1'b1, 1'b1, 4'd12, 1'b0, 1'b0}
                                     : {1'b1, 1'b0, 4'd8,  1'b0, 1'b1});
      tick();
    end

    // Backpressure with both requesters waiting.
    rsp_ready = 1'b0;
    samp();
    chk("bp_hs", ctl_vec, 8'h01);
    tick();
    tick();
    samp();
    chk("bp_resp", rsp_vec, {1'b1, 1'b0, 4'd8, 1'b0, 1'b1});
    for (int k = 0; k < 5; k++) begin
      tick();
      samp();
      chk("bp_hold_rsp", rsp_vec, {1'b1, 1'b0, 4'd8, 1'b0, 1'b1});
      chk("bp_hold_ctl", ctl_vec, 8'h04);
    end
    tick();
    rsp_ready = 1'b1;
    samp();
    chk("bp_release", rsp_vec, {1'b1, 1'b0, 4'd8, 1'b0, 1'b1});
    tick();
    samp();
    chk("bp_next_hs", ctl_vec, 8'h02);
    tick();
    drive0(1'b0, 4'd0, 4'd0, 1'b0);
    drive1(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    samp();
    chk("bp_next_resp", rsp_vec, {1'b1, 1'b1, 4'd12, 1'b0, 1'b0});
    tick();
    samp();
    chk("final_idle", ctl_vec, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
